// File: rtl/uart_pkg.sv
// Shared types and constants for the UART baud-rate generator.
// Optional tick outputs are controlled by the BAUD_TICK_EN macro.
package uart_pkg;

    localparam int PRESCALE_W = 8;

    typedef logic [PRESCALE_W-1:0] prescale_t;

    localparam prescale_t DEFAULT_PRESCALE = prescale_t'(16);

    // Counter width able to hold values 0..n-1 (at least one bit).
    function automatic int cnt_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_rate_generator_if.sv
// Signal bundle between the baud-rate generator and its UART consumers.
// rx_tick/tx_tick exist only when BAUD_TICK_EN is defined.
interface uart_baud_rate_generator_if #(
    parameter int PRESCALE_W = uart_pkg::PRESCALE_W
);

    logic [PRESCALE_W-1:0] prescale;
    logic                  tx_clk;
    logic                  rx_clk;
`ifdef BAUD_TICK_EN
    logic                  rx_tick;
    logic                  tx_tick;

    modport master (output prescale, input tx_clk, input rx_clk, input rx_tick, input tx_tick);
    modport slave  (input prescale, output tx_clk, output rx_clk, output rx_tick, output tx_tick);
`else
    modport master (output prescale, input tx_clk, input rx_clk);
    modport slave  (input prescale, output tx_clk, output rx_clk);
`endif

endinterface

// File: rtl/uart_clk_div.sv
// Fixed divide-by-N square-wave generator: high for floor(N/2) cycles, low for
// the rest, plus the look-ahead level and a wrap flag for cascaded stages.
module uart_clk_div
    import uart_pkg::*;
#(
    parameter int N = 2,
    parameter int W = cnt_width(N)
) (
    input  logic clk,
    input  logic rst,
    output logic div_clk,
    output logic div_clk_nxt,
    output logic wrap
);

    localparam logic [W-1:0] LAST = W'(N - 1);
    localparam logic [W-1:0] HALF = W'(N / 2);

    logic [W-1:0] cnt;
    logic [W-1:0] cnt_nxt;

    always_comb begin
        cnt_nxt     = (cnt == LAST) ? '0 : cnt + W'(1);
        wrap        = (cnt_nxt == '0);
        div_clk_nxt = (cnt_nxt < HALF);
    end

    // Reset to the last count so the first edge after release wraps and rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt     <= LAST;
            div_clk <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            div_clk <= div_clk_nxt;
        end
    end

endmodule

// File: rtl/uart_baud_rate_generator.sv
// UART rx (oversampling) and tx (bit) clock generator; tx = rx / prescale.
// Define BAUD_TICK_EN to add single-cycle rising-edge ticks for both clocks.
module uart_baud_rate_generator
    import uart_pkg::*;
#(
    parameter int RX_DIV     = 2,
    parameter int PRESCALE_W = uart_pkg::PRESCALE_W
) (
    input  logic                           clk,
    input  logic                           rst,
    uart_baud_rate_generator_if.slave      bus
);

    logic rx_clk;
    logic rx_clk_nxt;
    logic rx_wrap;

    uart_clk_div #(
        .N (RX_DIV)
    ) u_rx_div (
        .clk         (clk),
        .rst         (rst),
        .div_clk     (rx_clk),
        .div_clk_nxt (rx_clk_nxt),
        .wrap        (rx_wrap)
    );

    logic [PRESCALE_W-1:0] prescale;
    logic [PRESCALE_W-1:0] p_act;
    logic [PRESCALE_W-1:0] p_act_nxt;
    logic [PRESCALE_W-1:0] tx_cnt;
    logic [PRESCALE_W-1:0] tx_cnt_nxt;
    logic                  tx_clk;
    logic                  tx_clk_nxt;

    assign prescale = bus.prescale;

    // prescale is only taken at a tx period boundary (or while idle at 0),
    // so a mid-period change never shortens or glitches the current period.
    always_comb begin
        p_act_nxt  = p_act;
        tx_cnt_nxt = tx_cnt;
        if (rx_wrap) begin
            if ((p_act == '0) || (tx_cnt >= p_act - PRESCALE_W'(1))) begin
                p_act_nxt  = prescale;
                tx_cnt_nxt = '0;
            end else begin
                tx_cnt_nxt = tx_cnt + PRESCALE_W'(1);
            end
        end

        if (p_act_nxt == '0) begin
            tx_clk_nxt = 1'b0;
        end else if (p_act_nxt == PRESCALE_W'(1)) begin
            tx_clk_nxt = rx_clk_nxt;
        end else begin
            tx_clk_nxt = (tx_cnt_nxt < (p_act_nxt >> 1));
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p_act  <= '0;
            tx_cnt <= '0;
            tx_clk <= 1'b0;
        end else begin
            p_act  <= p_act_nxt;
            tx_cnt <= tx_cnt_nxt;
            tx_clk <= tx_clk_nxt;
        end
    end

    assign bus.rx_clk = rx_clk;
    assign bus.tx_clk = tx_clk;

`ifdef BAUD_TICK_EN
    logic rx_tick;
    logic tx_tick;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_tick <= 1'b0;
            tx_tick <= 1'b0;
        end else begin
            rx_tick <= rx_clk_nxt & ~rx_clk;
            tx_tick <= tx_clk_nxt & ~tx_clk;
        end
    end

    assign bus.rx_tick = rx_tick;
    assign bus.tx_tick = tx_tick;
`endif

endmodule

// File: tb/tb_uart_baud_rate_generator.sv
// Directed bench for uart_baud_rate_generator with RX_DIV=2 and RX_DIV=3 instances.
// Tick outputs are checked when BAUD_TICK_EN is defined.
module tb_uart_baud_rate_generator;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    uart_baud_rate_generator_if #(.PRESCALE_W(8)) bus2 ();
    uart_baud_rate_generator_if #(.PRESCALE_W(8)) bus3 ();

    uart_baud_rate_generator #(.RX_DIV(2), .PRESCALE_W(8)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    uart_baud_rate_generator #(.RX_DIV(3), .PRESCALE_W(8)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_low(input string tag);
        check_eq({tag, " rx2"}, 32'(bus2.rx_clk), 32'd0);
        check_eq({tag, " tx2"}, 32'(bus2.tx_clk), 32'd0);
        check_eq({tag, " rx3"}, 32'(bus3.rx_clk), 32'd0);
        check_eq({tag, " tx3"}, 32'(bus3.tx_clk), 32'd0);
`ifdef BAUD_TICK_EN
        check_eq({tag, " rx_tick2"}, 32'(bus2.rx_tick), 32'd0);
        check_eq({tag, " tx_tick2"}, 32'(bus2.tx_tick), 32'd0);
`endif
    endtask

    initial begin
        int exp_tx2;
        int exp_rx3;

        rst          = 1'b0;
        bus2.prescale = 8'd4;
        bus3.prescale = 8'd1;

        #12;
        check_all_low("reset");
        #8;
        rst = 1'b1;

        // prescale=4 on RX_DIV=2; prescale=1 on RX_DIV=3
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_rx3 = (((k - 1) % 3) == 0) ? 1 : 0;
            check_eq($sformatf("p1 rx2 k=%0d", k), 32'(bus2.rx_clk), 32'(k % 2));
            check_eq($sformatf("p1 tx2 k=%0d", k), 32'(bus2.tx_clk), 32'((((k - 1) % 8) < 4) ? 1 : 0));
            check_eq($sformatf("p1 rx3 k=%0d", k), 32'(bus3.rx_clk), 32'(exp_rx3));
            check_eq($sformatf("p1 tx3 k=%0d", k), 32'(bus3.tx_clk), 32'(exp_rx3));
`ifdef BAUD_TICK_EN
            check_eq($sformatf("p1 rx_tick2 k=%0d", k), 32'(bus2.rx_tick), 32'(k % 2));
            check_eq($sformatf("p1 tx_tick2 k=%0d", k), 32'(bus2.tx_tick), 32'((((k - 1) % 8) == 0) ? 1 : 0));
            check_eq($sformatf("p1 rx_tick3 k=%0d", k), 32'(bus3.rx_tick), 32'(exp_rx3));
            check_eq($sformatf("p1 tx_tick3 k=%0d", k), 32'(bus3.tx_tick), 32'(exp_rx3));
`endif
        end

        // prescale 4 -> 6 in the middle of the period starting at edge 17
        for (int k = 17; k <= 48; k++) begin
            step();
            if (k <= 24) exp_tx2 = (((k - 17) % 8) < 4) ? 1 : 0;
            else         exp_tx2 = (((k - 25) % 12) < 6) ? 1 : 0;
            exp_rx3 = (((k - 1) % 3) == 0) ? 1 : 0;
            check_eq($sformatf("p2 rx2 k=%0d", k), 32'(bus2.rx_clk), 32'(k % 2));
            check_eq($sformatf("p2 tx2 k=%0d", k), 32'(bus2.tx_clk), 32'(exp_tx2));
            check_eq($sformatf("p2 tx3 k=%0d", k), 32'(bus3.tx_clk), 32'(exp_rx3));
            if (k == 18) bus2.prescale = 8'd6;
        end

        // asynchronous reset at the start of a tx high phase
        step();
        check_eq("pre-reset rx2", 32'(bus2.rx_clk), 32'd1);
        check_eq("pre-reset tx2", 32'(bus2.tx_clk), 32'd1);
        check_eq("pre-reset rx3", 32'(bus3.rx_clk), 32'd1);
        check_eq("pre-reset tx3", 32'(bus3.tx_clk), 32'd1);
        #3;
        rst = 1'b0;
        #1;
        check_all_low("async reset");
        bus2.prescale = 8'd0;
        @(negedge clk);
        @(negedge clk);
        check_all_low("held reset");
        rst = 1'b1;

        // prescale=0 after restart, then 2 set after edge 20
        for (int k = 1; k <= 32; k++) begin
            step();
            exp_tx2 = (k <= 20) ? 0 : ((((k - 21) % 4) < 2) ? 1 : 0);
            exp_rx3 = (((k - 1) % 3) == 0) ? 1 : 0;
            check_eq($sformatf("p4 rx2 k=%0d", k), 32'(bus2.rx_clk), 32'(k % 2));
            check_eq($sformatf("p4 tx2 k=%0d", k), 32'(bus2.tx_clk), 32'(exp_tx2));
            check_eq($sformatf("p4 rx3 k=%0d", k), 32'(bus3.rx_clk), 32'(exp_rx3));
            check_eq($sformatf("p4 tx3 k=%0d", k), 32'(bus3.tx_clk), 32'(exp_rx3));
`ifdef BAUD_TICK_EN
            check_eq($sformatf("p4 tx_tick2 k=%0d", k), 32'(bus2.tx_tick),
                     32'(((k >= 21) && (((k - 21) % 4) == 0)) ? 1 : 0));
`endif
            if (k == 20) bus2.prescale = 8'd2;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
